// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS controller
// MC_BLE_EN adds the BLEEX state to the state enum.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd10,
    ST_ADDIWB  = 4'd11,
    ST_JEX     = 4'd12
`ifdef MC_BLE_EN
    , ST_BLEEX = 4'd9
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUCLS_NONE  = 2'd0,
    ALUCLS_ADD   = 2'd1,
    ALUCLS_SUB   = 2'd2,
    ALUCLS_FUNCT = 2'd3
  } alu_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ASB_B     = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - controller <-> datapath signal bundle
// master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       less;
  logic       memready;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       memwrite;
  logic       bytewrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero, less, memready,
    output iord, irwrite, pcen, regwrite, memwrite, bytewrite,
           regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero, less, memready,
    input  iord, irwrite, pcen, regwrite, memwrite, bytewrite,
           regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU control decode from state class and funct
// funct_illegal is only meaningful for the R-type execute class.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  alu_cls_t   alu_cls,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       funct_illegal
);

  always_comb begin
    alucontrol    = ALU_AND;
    funct_illegal = 1'b0;
    case (alu_cls)
      ALUCLS_ADD: alucontrol = ALU_ADD;
      ALUCLS_SUB: alucontrol = ALU_SUB;
      ALUCLS_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default: begin
            alucontrol    = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS main controller (Moore FSM)
// Define MC_BLE_EN to decode op 000110 as ble; otherwise it is illegal.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  alu_cls_t   alu_cls;
  logic       funct_illegal;
  logic [3:0] alucontrol;

  logic iord, irwrite, pcen, regwrite, memwrite, bytewrite;
  logic regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;

  mc_aludec u_aludec (
    .alu_cls       (alu_cls),
    .funct         (bus.funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH:  if (bus.memready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW, OP_SB: state_d = ST_MEMADR;
          OP_RTYPE:            state_d = ST_RTYPEEX;
          OP_BEQ:              state_d = ST_BEQEX;
`ifdef MC_BLE_EN
          OP_BLE:              state_d = ST_BLEEX;
`endif
          OP_ADDI:             state_d = ST_ADDIEX;
          OP_J:                state_d = ST_JEX;
          default: begin
            state_d   = ST_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMADR:  state_d = (bus.op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   if (bus.memready) state_d = ST_MEMWB;
      ST_MEMWR:   if (bus.memready) state_d = ST_FETCH;
      ST_RTYPEEX: begin
        state_d = ST_RTYPEWB;
        if (funct_illegal) illegal_d = 1'b1;
      end
      ST_ADDIEX:  state_d = ST_ADDIWB;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    iord      = 1'b0;
    irwrite   = 1'b0;
    pcen      = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    bytewrite = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = ASB_B;
    pcsrc     = PCSRC_ALU;
    alu_cls   = ALUCLS_NONE;
    case (state_q)
      ST_FETCH: begin
        alusrcb = ASB_FOUR;
        alu_cls = ALUCLS_ADD;
        irwrite = bus.memready;
        pcen    = bus.memready;
      end
      ST_DECODE: begin
        alusrcb = ASB_IMMSH;
        alu_cls = ALUCLS_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ASB_IMM;
        alu_cls = ALUCLS_ADD;
      end
      ST_MEMRD: iord = 1'b1;
      ST_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      ST_MEMWR: begin
        iord      = 1'b1;
        memwrite  = 1'b1;
        bytewrite = (bus.op == OP_SB);
      end
      ST_RTYPEEX: begin
        alusrca = 1'b1;
        alu_cls = ALUCLS_FUNCT;
      end
      ST_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ST_BEQEX: begin
        alusrca = 1'b1;
        alu_cls = ALUCLS_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pcen    = bus.zero;
      end
`ifdef MC_BLE_EN
      ST_BLEEX: begin
        alusrca = 1'b1;
        alu_cls = ALUCLS_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pcen    = bus.zero | bus.less;
      end
`endif
      ST_ADDIWB: regwrite = 1'b1;
      ST_JEX: begin
        pcsrc = PCSRC_JUMP;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are held off for as long as reset is asserted, not just until the next edge.
  assign bus.irwrite    = irwrite & reset;
  assign bus.pcen       = pcen & reset;
  assign bus.regwrite   = regwrite & reset;
  assign bus.memwrite   = memwrite & reset;
  assign bus.bytewrite  = bytewrite & reset;
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
// Control vector order: iord irwrite pcen regwrite memwrite bytewrite regdst memtoreg alusrca alusrcb pcsrc alucontrol.
module tb_mc_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [16:0] ctrl;
  assign ctrl = {bus.iord, bus.irwrite, bus.pcen, bus.regwrite, bus.memwrite, bus.bytewrite,
                 bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol};

  localparam logic [16:0] S_RST      = {9'b0_0_0_0_0_0_0_0_0, 2'b01, 2'b00, 4'b0010};
  localparam logic [16:0] S_FETCH    = {9'b0_1_1_0_0_0_0_0_0, 2'b01, 2'b00, 4'b0010};
  localparam logic [16:0] S_FWAIT    = {9'b0_0_0_0_0_0_0_0_0, 2'b01, 2'b00, 4'b0010};
  localparam logic [16:0] S_DECODE   = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 4'b0010};
  localparam logic [16:0] S_MEMADR   = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 4'b0010};
  localparam logic [16:0] S_MEMRD    = {9'b1_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 4'b0000};
  localparam logic [16:0] S_MEMWB    = {9'b0_0_0_1_0_0_0_1_0, 2'b00, 2'b00, 4'b0000};
  localparam logic [16:0] S_MEMWR_SB = {9'b1_0_0_0_1_1_0_0_0, 2'b00, 2'b00, 4'b0000};
  localparam logic [16:0] S_RX_SLT   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 4'b0111};
  localparam logic [16:0] S_RX_ADD   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 4'b0010};
  localparam logic [16:0] S_RTYPEWB  = {9'b0_0_0_1_0_0_1_0_0, 2'b00, 2'b00, 4'b0000};
  localparam logic [16:0] S_BEQ_NT   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 4'b0110};
  localparam logic [16:0] S_BLE_T    = {9'b0_0_1_0_0_0_0_0_1, 2'b00, 2'b01, 4'b0110};
  localparam logic [16:0] S_ADDIWB   = {9'b0_0_0_1_0_0_0_0_0, 2'b00, 2'b00, 4'b0000};
  localparam logic [16:0] S_JEX      = {9'b0_0_1_0_0_0_0_0_0, 2'b00, 2'b10, 4'b0000};

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    #1;
    checks++;
    assert (ctrl === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, ctrl, exp);
    end
  endtask

  task automatic chk_ill(input string tag, input logic exp);
    #1;
    checks++;
    assert (bus.illegal === exp) else begin
      errors++;
      $error("FAIL %s illegal observed=%b expected=%b", tag, bus.illegal, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
    bus.less = 1'b0;
    bus.memready = 1'b1;

    repeat (3) begin
      nxt();
      chk("reset_ctrl", S_RST);
      chk_ill("reset_ill", 1'b0);
    end
    rst_n = 1'b1;
    chk("lw_fetch", S_FETCH);
    nxt(); chk("lw_decode", S_DECODE);
    nxt(); chk("lw_memadr", S_MEMADR);
    nxt(); chk("lw_memrd", S_MEMRD);
    nxt(); chk("lw_memwb", S_MEMWB);

    nxt(); bus.memready = 1'b0; chk("fetch_wait", S_FWAIT);
    nxt(); bus.memready = 1'b1; chk("fetch_ready", S_FETCH);
    bus.op = 6'b101000;
    nxt(); chk("sb_decode", S_DECODE);
    nxt(); chk("sb_memadr", S_MEMADR);
    nxt(); bus.memready = 1'b0; chk("sb_memwr0", S_MEMWR_SB);
    nxt(); chk("sb_memwr1", S_MEMWR_SB);
    nxt(); bus.memready = 1'b1; chk("sb_memwr2", S_MEMWR_SB);
    nxt(); chk("sb_fetch", S_FETCH);

    bus.op = 6'b000100;
    nxt(); chk("beq_decode", S_DECODE);
    nxt(); chk("beq_nt", S_BEQ_NT);
    nxt(); chk("beq_fetch", S_FETCH);

    bus.op = 6'b000000; bus.funct = 6'b101010;
    nxt(); chk("slt_decode", S_DECODE);
    nxt(); chk("slt_ex", S_RX_SLT);
    nxt(); chk("slt_wb", S_RTYPEWB);
    chk_ill("slt_ill", 1'b0);
    nxt(); chk("slt_fetch", S_FETCH);

    bus.op = 6'b001000;
    nxt(); chk("addi_decode", S_DECODE);
    nxt(); chk("addi_ex", S_MEMADR);
    nxt(); chk("addi_wb", S_ADDIWB);
    nxt(); chk("addi_fetch", S_FETCH);

    bus.op = 6'b000010;
    nxt(); chk("j_decode", S_DECODE);
    nxt(); chk("j_ex", S_JEX);
    nxt(); chk("j_fetch", S_FETCH);

    bus.op = 6'b000000; bus.funct = 6'b111111;
    nxt(); chk("badf_decode", S_DECODE);
    nxt(); chk("badf_ex", S_RX_ADD);
    chk_ill("badf_ex_ill", 1'b0);
    nxt(); chk("badf_wb", S_RTYPEWB);
    chk_ill("badf_wb_ill", 1'b1);
    nxt(); chk("badf_fetch", S_FETCH);

    // Reset mid-instruction clears the sticky flag and returns to FETCH.
    bus.op = 6'b100011;
    nxt(); chk("abort_decode", S_DECODE);
    rst_n = 1'b0;
    chk("abort_rst", S_RST);
    chk_ill("abort_ill", 1'b0);
    nxt(); chk("abort_rst2", S_RST);
    rst_n = 1'b1;
    chk("abort_fetch", S_FETCH);

    bus.op = 6'b000110; bus.zero = 1'b0; bus.less = 1'b1;
    nxt(); chk("ble_decode", S_DECODE);
    nxt();
`ifdef MC_BLE_EN
    chk("ble_taken", S_BLE_T);
    chk_ill("ble_ill", 1'b0);
    nxt(); chk("ble_fetch", S_FETCH);
`else
    chk("ble_fetch", S_FETCH);
    chk_ill("ble_ill", 1'b1);
    rst_n = 1'b0;
    chk_ill("ble_rst_ill", 1'b0);
    nxt();
    rst_n = 1'b1;
    chk("ble_rel_fetch", S_FETCH);
`endif

    bus.op = 6'b111111; bus.less = 1'b0;
    nxt(); chk("ill_decode", S_DECODE);
    chk_ill("ill_decode_ill", 1'b0);
    nxt(); chk("ill_fetch", S_FETCH);
    chk_ill("ill_set", 1'b1);
    bus.op = 6'b000010;
    nxt(); chk("ill_j_decode", S_DECODE);
    nxt(); chk("ill_j_ex", S_JEX);
    chk_ill("ill_sticky", 1'b1);
    nxt(); chk_ill("ill_sticky2", 1'b1);
    rst_n = 1'b0;
    chk_ill("ill_clear", 1'b0);
    chk("ill_rst_ctrl", S_RST);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller that sequences a shared-memory MIPS datapath (single memory for instructions and data, one ALU reused across cycles). Decodes opcode/funct from the instruction register and steps a Moore FSM that drives mux selects, register/memory write strobes and the 4-bit ALU control. Adds a memory-ready handshake, `sb` byte writes, the `ble` branch and a sticky illegal-opcode flag. Sits beside the datapath, replacing the single-cycle `controller` when the core is built multicycle.

## Interface
- No parameters.
- `clk  in  1`  rising-edge clock.
- `reset  in  1`  asynchronous, active-low (asserted at 0).
- `op  in  6`  instruction register [31:26].
- `funct  in  6`  instruction register [5:0].
- `zero  in  1`, `less  in  1`  ALU flags (A==B, A<B signed).
- `memready  in  1`  memory completes the current access this cycle.
- `iord  out  1`  memory address: 0=PC, 1=ALUOut.
- `irwrite  out  1`, `pcen  out  1`, `regwrite  out  1`, `memwrite  out  1`, `bytewrite  out  1`  write strobes.
- `regdst  out  1`, `memtoreg  out  1`, `alusrca  out  1`  selects.
- `alusrcb  out  2`  00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- `pcsrc  out  2`  00=ALU result, 01=ALUOut, 10=jump target.
- `alucontrol  out  4`  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- `illegal  out  1`  sticky: an undecodable opcode was fetched.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BLEEX, ADDIEX, ADDIWB, JEX.
- FETCH: iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00. Waits while memready=0; on memready=1 irwrite=1, pcen=1, -> DECODE.
- DECODE: alusrca=0, alusrcb=11, ADD (branch target to ALUOut). Next by op: 100011 lw / 101011 sw / 101000 sb -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 000110 -> BLEEX; 001000 -> ADDIEX; 000010 -> JEX; else set `illegal`, -> FETCH.
- MEMADR: alusrca=1, alusrcb=10, ADD; lw -> MEMRD, sw/sb -> MEMWR.
- MEMRD: iord=1; hold until memready, then -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1, bytewrite=1 iff op=sb; hold until memready, then -> FETCH. memwrite stays high every cycle of the wait.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; other funct -> ADD, set `illegal`) -> RTYPEWB. RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero -> FETCH. BLEEX: same, pcen=zero|less.
- ADDIEX: alusrca=1, alusrcb=10, ADD -> ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcen=1 -> FETCH.
- Any unlisted state encoding -> FETCH.
- Unlisted outputs are 0 in every state.

## Timing
- Reset (reset=0): state=FETCH, illegal=0 immediately; while reset is asserted all strobes (irwrite, pcen, regwrite, memwrite, bytewrite) forced 0; selects show FETCH values.
- Reset mid-instruction aborts it; first cycle after release is FETCH.
- Outputs are combinational from state (plus zero/less/memready for pcen/irwrite); no registered output delay.
- Cycles at memready=1 throughout: lw 5, sw/sb 4, R-type 4, addi 4, beq/ble/j 3, illegal 2. Each memready=0 cycle in FETCH/MEMRD/MEMWR adds one.
- `illegal` clears only on reset.

## Configuration
- `MC_BLE_EN`: defined -> op 000110 decodes to BLEEX as above. Undefined -> BLEEX state absent, 000110 treated as illegal (sets `illegal`, -> FETCH).

## Structure
- Package `mc_ctrl_pkg`: state enum (4-bit), opcode and funct localparams, alucontrol encodings, alusrcb/pcsrc encodings.
- Sub-module `mc_aludec`: combinational mapping of state class + funct to alucontrol and funct-illegal; FSM stays in `mc_controller`.

## Test plan
- reset=0 for 3 cycles, memready=1 -> all strobes 0, state FETCH; release -> irwrite=1, pcen=1 on first cycle.
- lw (op=100011), memready=1 -> sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1, memtoreg=1 exactly in cycle 5.
- sb (op=101000), memready low 2 cycles in MEMWR -> memwrite=1, bytewrite=1 for 3 cycles, then FETCH.
- beq with zero=0 -> pcen=0 in BEQEX; ble with zero=0, less=1 -> pcen=1, pcsrc=01 (undefined MC_BLE_EN: illegal=1, no BLEEX).
- R-type funct=101010 -> alucontrol=0111 in RTYPEEX, regdst=1, regwrite=1 next cycle; funct=111111 -> illegal=1.
- op=111111 -> illegal=1 after DECODE, returns to FETCH, stays 1 until reset=0.
